bullet_sweep_engine: RTL and testbench

- Parametrised per-frame bullet updater for the VGA shooter.
- On each begin_draw it walks a bullet table in single-port RAM. For every active bullet it:
  - erases the old pixel;
  - applies a signed velocity;
  - writes back the new position, or retires the bullet when it leaves the screen;
  - draws the new pixel.
- Sits between the frame sequencer (begin_draw/done), the bullet RAM and the VGA pixel writer.

---
 rtl/bullet_pkg.sv | 47 ++++
 rtl/bullet_sweep_engine_if.sv | 27 ++
 rtl/bullet_sweep_engine_step.sv | 50 +++++
 rtl/bullet_sweep_engine.sv | 209 ++++++++++++++++++++
 tb/tb_bullet_sweep_engine.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/bullet_pkg.sv
// Shared definitions for the bullet sweep engine: FSM states, record word
// offsets, status-word bit positions and velocity field accessors.
package bullet_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_STAT,
    S_RD_VEL,
    S_RD_X,
    S_RD_Y,
    S_ERASE,
    S_CALC,
    S_WR_X,
    S_WR_Y,
    S_DRAW,
    S_KILL,
    S_NEXT,
    S_DONE
  } state_e;

  // Word offsets inside a 4-word bullet record
  localparam logic [1:0] OFF_STAT = 2'd0;
  localparam logic [1:0] OFF_VEL  = 2'd1;
  localparam logic [1:0] OFF_X    = 2'd2;
  localparam logic [1:0] OFF_Y    = 2'd3;

  // Status word layout
  localparam int STAT_ACTIVE_BIT = 7;
  localparam int STAT_COLOR_LSB  = 4;

  // Width of the signed position arithmetic; wide enough that any 8-bit
  // coordinate plus a 4-bit velocity can never overflow.
  localparam int CALC_W = 10;

  function automatic logic signed [3:0] vel_dx(input logic [7:0] v);
    return $signed(v[7:4]);
  endfunction

  function automatic logic signed [3:0] vel_dy(input logic [7:0] v);
    return $signed(v[3:0]);
  endfunction

  function automatic logic [2:0] stat_color(input logic [7:0] s);
    return s[STAT_COLOR_LSB +: 3];
  endfunction

endpackage

// File: rtl/bullet_sweep_engine_if.sv
// Bundle of frame-sequencer handshake, bullet RAM port and VGA pixel writer
// signals. master = sweep engine side, slave = environment side.
interface bullet_sweep_engine_if #(
  parameter int ADDR_W = 8
);
  logic              begin_draw;
  logic              done;
  logic [ADDR_W-1:0] address;
  logic [7:0]        DataOut;
  logic [7:0]        WriteData;
  logic              RamWrite;
  logic [7:0]        x;
  logic [6:0]        y;
  logic [2:0]        color;
  logic              drawEn;
  logic [ADDR_W-1:0] active_count;

  modport master (
    input  begin_draw, DataOut,
    output done, address, WriteData, RamWrite, x, y, color, drawEn, active_count
  );

  modport slave (
    output begin_draw, DataOut,
    input  done, address, WriteData, RamWrite, x, y, color, drawEn, active_count
  );
endinterface

// File: rtl/bullet_sweep_engine_step.sv
// bullet_step: combinational next-position and bounds check for one bullet.
// Optional macro BULLET_WRAP_EN: wrap off-screen coordinates modulo the
// screen size instead of flagging them out of bounds.
module bullet_step
  import bullet_pkg::*;
#(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic [7:0]        x,
  input  logic [6:0]        y,
  input  logic signed [3:0] dx,
  input  logic signed [3:0] dy,
  output logic [7:0]        nx,
  output logic [6:0]        ny,
  output logic              oob
);
  localparam logic signed [CALC_W-1:0] W_S = CALC_W'(SCREEN_W);
  localparam logic signed [CALC_W-1:0] H_S = CALC_W'(SCREEN_H);

  logic signed [CALC_W-1:0] w_nxs;
  logic signed [CALC_W-1:0] w_nys;

  assign w_nxs = $signed(CALC_W'(x)) + CALC_W'(dx);
  assign w_nys = $signed(CALC_W'(y)) + CALC_W'(dy);

`ifdef BULLET_WRAP_EN
  logic signed [CALC_W-1:0] w_nxw;
  logic signed [CALC_W-1:0] w_nyw;

  // Fold a single step past either edge back onto the opposite edge
  always_comb begin
    w_nxw = w_nxs;
    w_nyw = w_nys;
    if (w_nxs < 0)         w_nxw = w_nxs + W_S;
    else if (w_nxs >= W_S) w_nxw = w_nxs - W_S;
    if (w_nys < 0)         w_nyw = w_nys + H_S;
    else if (w_nys >= H_S) w_nyw = w_nys - H_S;
  end

  assign nx  = 8'(w_nxw);
  assign ny  = 7'(w_nyw);
  assign oob = 1'b0;
`else
  assign nx  = 8'(w_nxs);
  assign ny  = 7'(w_nys);
  assign oob = (w_nxs < 0) || (w_nxs >= W_S) || (w_nys < 0) || (w_nys >= H_S);
`endif

endmodule

// File: rtl/bullet_sweep_engine.sv
// bullet_sweep_engine: on each begin_draw, walks the bullet table, erases,
// moves, writes back (or retires) and redraws every active bullet.
// Optional macro BULLET_WRAP_EN (in bullet_step): wrap instead of retiring.
// Every active record costs 14 cycles whether it survives or is retired;
// inactive records cost 3.
module bullet_sweep_engine
  import bullet_pkg::*;
#(
  parameter int         NUM_BULLETS = 64,
  parameter int         SCREEN_W    = 160,
  parameter int         SCREEN_H    = 120,
  parameter logic [2:0] BG_COLOR    = 3'b000,
  parameter int         ADDR_W      = 8
) (
  input logic                   clk,
  input logic                   reset,
  bullet_sweep_engine_if.master bus
);
  localparam int IDX_W = ADDR_W - 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BULLETS - 1);

  state_e             r_state;
  logic [1:0]         r_sub;
  logic [IDX_W-1:0]   r_idx;
  logic [ADDR_W-1:0]  r_count;
  logic [ADDR_W-1:0]  r_active_count;
  logic [7:0]         r_stat;
  logic [7:0]         r_vel;
  logic [7:0]         r_x;
  logic [6:0]         r_y;

  state_e             w_state_nxt;
  logic [1:0]         w_sub_nxt;
  logic               w_clr, w_adv, w_inc, w_latch;
  logic [1:0]         w_off;
  logic [7:0]         w_wdata;
  logic               w_we, w_draw, w_done;
  logic [7:0]         w_x;
  logic [6:0]         w_y;
  logic [2:0]         w_color;
  logic signed [3:0]  w_dx, w_dy;
  logic [7:0]         w_nx;
  logic [6:0]         w_ny;
  logic               w_oob;

  assign w_dx = vel_dx(r_vel);
  assign w_dy = vel_dy(r_vel);

  bullet_step #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) u_step (
    .x   (r_x),
    .y   (r_y),
    .dx  (w_dx),
    .dy  (w_dy),
    .nx  (w_nx),
    .ny  (w_ny),
    .oob (w_oob)
  );

  // Control state: FSM state, wait sub-counter, record index and counts
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_sub          <= 2'd0;
      r_idx          <= '0;
      r_count        <= '0;
      r_active_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sub   <= w_sub_nxt;
      if (w_clr) begin
        r_idx   <= '0;
        r_count <= '0;
      end else begin
        if (w_adv) r_idx   <= r_idx + IDX_W'(1);
        if (w_inc) r_count <= r_count + ADDR_W'(1);
      end
      if (w_latch) r_active_count <= r_count;
    end
  end

  // Record fields are captured on the second (data-valid) cycle of each read
  always_ff @(posedge clk) begin
    if (r_sub == 2'd1) begin
      case (r_state)
        S_RD_STAT: r_stat <= bus.DataOut;
        S_RD_VEL:  r_vel  <= bus.DataOut;
        S_RD_X:    r_x    <= bus.DataOut;
        S_RD_Y:    r_y    <= bus.DataOut[6:0];
        default: ;
      endcase
    end
  end

  // Next-state and Moore outputs; every output defaults to an idle value
  always_comb begin
    w_state_nxt = r_state;
    w_sub_nxt   = 2'd0;
    w_clr       = 1'b0;
    w_adv       = 1'b0;
    w_inc       = 1'b0;
    w_latch     = 1'b0;
    w_off       = OFF_STAT;
    w_wdata     = 8'd0;
    w_we        = 1'b0;
    w_draw      = 1'b0;
    w_done      = 1'b0;
    w_x         = 8'd0;
    w_y         = 7'd0;
    w_color     = 3'd0;
    case (r_state)
      S_IDLE: begin
        if (bus.begin_draw) begin
          w_clr       = 1'b1;
          w_state_nxt = S_RD_STAT;
        end
      end
      S_RD_STAT: begin
        w_off = OFF_STAT;
        if (r_sub == 2'd0) w_sub_nxt = 2'd1;
        else w_state_nxt = bus.DataOut[STAT_ACTIVE_BIT] ? S_RD_VEL : S_NEXT;
      end
      S_RD_VEL: begin
        w_off = OFF_VEL;
        if (r_sub == 2'd0) w_sub_nxt = 2'd1;
        else w_state_nxt = S_RD_X;
      end
      S_RD_X: begin
        w_off = OFF_X;
        if (r_sub == 2'd0) w_sub_nxt = 2'd1;
        else w_state_nxt = S_RD_Y;
      end
      S_RD_Y: begin
        w_off = OFF_Y;
        if (r_sub == 2'd0) w_sub_nxt = 2'd1;
        else w_state_nxt = S_ERASE;
      end
      S_ERASE: begin
        w_draw      = 1'b1;
        w_x         = r_x;
        w_y         = r_y;
        w_color     = BG_COLOR;
        w_state_nxt = S_CALC;
      end
      S_CALC: w_state_nxt = w_oob ? S_KILL : S_WR_X;
      S_WR_X: begin
        w_off       = OFF_X;
        w_we        = 1'b1;
        w_wdata     = w_nx;
        w_state_nxt = S_WR_Y;
      end
      S_WR_Y: begin
        w_off       = OFF_Y;
        w_we        = 1'b1;
        w_wdata     = {1'b0, w_ny};
        w_state_nxt = S_DRAW;
      end
      S_DRAW: begin
        w_draw      = 1'b1;
        w_x         = w_nx;
        w_y         = w_ny;
        w_color     = stat_color(r_stat);
        w_inc       = 1'b1;
        w_state_nxt = S_NEXT;
      end
      S_KILL: begin
        // One write cycle, then two idle cycles so a retired bullet takes
        // as long as a surviving one (WR_X, WR_Y, DRAW).
        w_off = OFF_STAT;
        if (r_sub == 2'd0) begin
          w_we      = 1'b1;
          w_wdata   = r_stat & ~(8'd1 << STAT_ACTIVE_BIT);
          w_sub_nxt = 2'd1;
        end else if (r_sub == 2'd1) begin
          w_sub_nxt = 2'd2;
        end else begin
          w_state_nxt = S_NEXT;
        end
      end
      S_NEXT: begin
        if (r_idx == LAST_IDX) begin
          w_latch     = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_adv       = 1'b1;
          w_state_nxt = S_RD_STAT;
        end
      end
      S_DONE: begin
        w_done = 1'b1;
        if (!bus.begin_draw) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.address      = {r_idx, w_off};
  assign bus.WriteData    = w_wdata;
  assign bus.RamWrite     = w_we;
  assign bus.drawEn       = w_draw;
  assign bus.x            = w_x;
  assign bus.y            = w_y;
  assign bus.color        = w_color;
  assign bus.done         = w_done;
  assign bus.active_count = r_active_count;

endmodule

// File: tb/tb_bullet_sweep_engine.sv
// Directed bench for bullet_sweep_engine: per-record vector table plus
// hand-written sequences for restart, held begin_draw and mid-sweep reset.
module tb_bullet_sweep_engine;
  localparam int NB = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bullet_sweep_engine_if #(.ADDR_W(8)) bus ();

  bullet_sweep_engine #(
    .NUM_BULLETS (NB),
    .SCREEN_W    (160),
    .SCREEN_H    (120),
    .BG_COLOR    (3'b000),
    .ADDR_W      (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0] mem [0:255];
  always @(posedge clk) begin
    bus.DataOut <= mem[bus.address];
    if (bus.RamWrite) mem[bus.address] = bus.WriteData;
  end

  int n_draw = 0, n_wr = 0, n_both = 0;
  logic [7:0] ev_x [0:255];
  logic [6:0] ev_y [0:255];
  logic [2:0] ev_c [0:255];
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.drawEn) begin
        ev_x[n_draw % 256] = bus.x;
        ev_y[n_draw % 256] = bus.y;
        ev_c[n_draw % 256] = bus.color;
        n_draw++;
      end
      if (bus.RamWrite) n_wr++;
      if (bus.drawEn && bus.RamWrite) n_both++;
    end
  end

  int nchk = 0, nfail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic clear_mem();
    for (int a = 0; a < 256; a++) mem[a] = 8'd0;
  endtask

  task automatic load(input int idx, input logic [7:0] st, input logic [7:0] vel,
                      input logic [7:0] px, input logic [7:0] py);
    mem[idx*4]   = st;
    mem[idx*4+1] = vel;
    mem[idx*4+2] = px;
    mem[idx*4+3] = py;
  endtask

  // Raise begin_draw, count edges until done, then drop it and let FSM idle
  task automatic sweep(output int cyc, output bit ok);
    bus.begin_draw = 1'b1;
    cyc = 0;
    ok  = 1'b0;
    while (cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
    end
    bus.begin_draw = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    int         idx;
    logic [7:0] st, vel, x, y;
    logic [7:0] ex_st, ex_x, ex_y;
    int         ex_cnt, ex_draws, ex_wr, ex_col;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int cyc, d0, w0, b;
    bit ok;

    // idx, status, vel, x, y | status', x', y', count, draws, writes, colour
    vecs[0] = '{0,  8'hD3, 8'h2F, 8'd10,  8'd20,  8'hD3, 8'd12,  8'd19,  1, 2, 2, 5};
    vecs[2] = '{5,  8'hF0, 8'h00, 8'd80,  8'd60,  8'hF0, 8'd80,  8'd60,  1, 2, 2, 7};
    vecs[5] = '{2,  8'hC0, 8'h21, 8'd157, 8'd118, 8'hC0, 8'd159, 8'd119, 1, 2, 2, 4};
    vecs[6] = '{3,  8'hE0, 8'h78, 8'd100, 8'd8,   8'hE0, 8'd107, 8'd0,   1, 2, 2, 6};
    vecs[8] = '{1,  8'h7F, 8'h11, 8'd3,   8'd3,   8'h7F, 8'd3,   8'd3,   0, 0, 0, 0};
`ifdef BULLET_WRAP_EN
    vecs[1] = '{0,  8'hB0, 8'h30, 8'd158, 8'd50,  8'hB0, 8'd1,   8'd50,  1, 2, 2, 3};
    vecs[3] = '{63, 8'h90, 8'h0F, 8'd30,  8'd0,   8'h90, 8'd30,  8'd119, 1, 2, 2, 1};
    vecs[4] = '{7,  8'hA5, 8'hF0, 8'd0,   8'd5,   8'hA5, 8'd159, 8'd5,   1, 2, 2, 2};
    vecs[7] = '{4,  8'hC0, 8'h01, 8'd5,   8'd119, 8'hC0, 8'd5,   8'd0,   1, 2, 2, 4};
`else
    vecs[1] = '{0,  8'hB0, 8'h30, 8'd158, 8'd50,  8'h30, 8'd158, 8'd50,  0, 1, 1, 3};
    vecs[3] = '{63, 8'h90, 8'h0F, 8'd30,  8'd0,   8'h10, 8'd30,  8'd0,   0, 1, 1, 1};
    vecs[4] = '{7,  8'hA5, 8'hF0, 8'd0,   8'd5,   8'h25, 8'd0,   8'd5,   0, 1, 1, 2};
    vecs[7] = '{4,  8'hC0, 8'h01, 8'd5,   8'd119, 8'h40, 8'd5,   8'd119, 0, 1, 1, 4};
`endif

    clear_mem();
    reset = 1'b1;
    bus.begin_draw = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", bus.done, 0);
    chk("rst_drawEn", bus.drawEn, 0);
    chk("rst_RamWrite", bus.RamWrite, 0);
    chk("rst_address", bus.address, 0);
    chk("rst_WriteData", bus.WriteData, 0);
    chk("rst_x", bus.x, 0);
    chk("rst_y", bus.y, 0);
    chk("rst_color", bus.color, 0);
    chk("rst_active_count", bus.active_count, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      clear_mem();
      load(vecs[i].idx, vecs[i].st, vecs[i].vel, vecs[i].x, vecs[i].y);
      b  = vecs[i].idx * 4;
      d0 = n_draw;
      w0 = n_wr;
      sweep(cyc, ok);
      chk($sformatf("v%0d_done_seen", i), ok, 1);
      chk($sformatf("v%0d_cycles", i), cyc, 3*NB + 1 + (vecs[i].st[7] ? 11 : 0));
      chk($sformatf("v%0d_stat", i), mem[b], vecs[i].ex_st);
      chk($sformatf("v%0d_x", i), mem[b+2], vecs[i].ex_x);
      chk($sformatf("v%0d_y", i), mem[b+3], vecs[i].ex_y);
      chk($sformatf("v%0d_active_count", i), bus.active_count, vecs[i].ex_cnt);
      chk($sformatf("v%0d_draws", i), n_draw - d0, vecs[i].ex_draws);
      chk($sformatf("v%0d_writes", i), n_wr - w0, vecs[i].ex_wr);
      if (vecs[i].ex_draws >= 1) begin
        chk($sformatf("v%0d_erase_x", i), ev_x[d0 % 256], vecs[i].x);
        chk($sformatf("v%0d_erase_y", i), ev_y[d0 % 256], vecs[i].y);
        chk($sformatf("v%0d_erase_c", i), ev_c[d0 % 256], 0);
      end
      if (vecs[i].ex_draws == 2) begin
        chk($sformatf("v%0d_draw_x", i), ev_x[(d0+1) % 256], vecs[i].ex_x);
        chk($sformatf("v%0d_draw_y", i), ev_y[(d0+1) % 256], vecs[i].ex_y);
        chk($sformatf("v%0d_draw_c", i), ev_c[(d0+1) % 256], vecs[i].ex_col);
      end
    end

    // Two bullets; begin_draw held after done must not restart the sweep
    clear_mem();
    load(0,  8'hD3, 8'h2F, 8'd10, 8'd20);
    load(10, 8'h80, 8'hF1, 8'd50, 8'd50);
    bus.begin_draw = 1'b1;
    cyc = 0;
    ok  = 1'b0;
    while (cyc < 3000 && !ok) begin
      @(posedge clk); #1;
      cyc++;
      ok = bus.done;
    end
    chk("hold_done_seen", ok, 1);
    chk("hold_cycles", cyc, 3*NB + 1 + 22);
    d0 = n_draw;
    w0 = n_wr;
    b  = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (!bus.done) b++;
    end
    chk("hold_done_low_cycles", b, 0);
    chk("hold_no_draw", n_draw - d0, 0);
    chk("hold_no_write", n_wr - w0, 0);
    chk("hold_x0", mem[2], 12);
    chk("hold_active_count", bus.active_count, 2);
    bus.begin_draw = 1'b0;
    @(posedge clk); #1;
    chk("hold_done_drops", bus.done, 0);
    sweep(cyc, ok);
    chk("resweep_done_seen", ok, 1);
    chk("resweep_x0", mem[2], 14);
    chk("resweep_y0", mem[3], 18);
    chk("resweep_x10", mem[42], 48);
    chk("resweep_y10", mem[43], 52);
    chk("resweep_active_count", bus.active_count, 2);

    // Reset landing in WR_X aborts the sweep, leaving x written but not y
    clear_mem();
    load(0, 8'hD3, 8'h2F, 8'd10, 8'd20);
    bus.begin_draw = 1'b1;
    cyc = 0;
    ok  = 1'b0;
    while (cyc < 200 && !ok) begin
      @(posedge clk); #1;
      cyc++;
      ok = bus.RamWrite;
    end
    chk("rstmid_wrx_seen", ok, 1);
    chk("rstmid_wrx_addr", bus.address, 2);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_RamWrite", bus.RamWrite, 0);
    chk("rstmid_drawEn", bus.drawEn, 0);
    chk("rstmid_done", bus.done, 0);
    chk("rstmid_address", bus.address, 0);
    chk("rstmid_active_count", bus.active_count, 0);
    bus.begin_draw = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rstmid_x_partial", mem[2], 12);
    chk("rstmid_y_untouched", mem[3], 20);
    sweep(cyc, ok);
    chk("rstmid_clean_done", ok, 1);
    chk("rstmid_clean_cycles", cyc, 3*NB + 1 + 11);
    chk("rstmid_clean_x", mem[2], 14);
    chk("rstmid_clean_y", mem[3], 19);
    chk("rstmid_clean_count", bus.active_count, 1);

    chk("drawEn_RamWrite_overlap", n_both, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
    $finish;
  end

endmodule
